// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue:
// word type, default depth and launch FSM encoding.
package uart_pkg;

   localparam int unsigned UART_QUEUE_DEPTH = 8;
   localparam int unsigned UART_WORD_W = 9;

   typedef logic [UART_WORD_W-1:0] uart_word_t;

   typedef enum logic [1:0] {
      LAUNCH_IDLE      = 2'd0,
      LAUNCH_SEND      = 2'd1,
      LAUNCH_WAIT_BUSY = 2'd2,
      LAUNCH_WAIT_DONE = 2'd3
   } launch_state_t;

endpackage

// File: rtl/uart_tx_queue_fifo.sv
// Circular word buffer with registered occupancy flags.
// Full/empty/count always reflect the post-edge occupancy.
module uart_tx_queue_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = UART_QUEUE_DEPTH
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           push,
   input  uart_word_t                     push_data,
   input  logic                           pop,
   output uart_word_t                     head,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   uart_word_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;
   logic [CNT_W-1:0] count_nxt;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({push_ok, pop_ok})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok)
            wr_ptr <= bump(wr_ptr);
         if (pop_ok)
            rd_ptr <= bump(rd_ptr);
         count <= count_nxt;
         full  <= (count_nxt == CNT_W'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   // Storage is deliberately left uncleared on reset.
   always_ff @(posedge clock) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Word queue in front of a uart_tx: pops one word per completed
// ready handshake and strobes tx_send for exactly one cycle.
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = UART_QUEUE_DEPTH
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           wr_en,
   input  logic [8:0]                     wr_data,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           overflow,
   output logic                           tx_send,
   output logic [8:0]                     tx_data,
   input  logic                           tx_ready
);

   launch_state_t state;
   uart_word_t    head;
   logic          pop;

   assign pop = (state == LAUNCH_IDLE) & ~empty & tx_ready;

   uart_tx_queue_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_ff @(posedge clock) begin
      if (reset)
         overflow <= 1'b0;
      else if (wr_en && full)
         overflow <= 1'b1;
   end

   // A launch completes only after ready falls and rises again.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= LAUNCH_IDLE;
         tx_send <= 1'b0;
         tx_data <= '0;
      end else begin
         tx_send <= 1'b0;
         unique case (state)
            LAUNCH_IDLE: begin
               if (pop) begin
                  tx_data <= head;
                  tx_send <= 1'b1;
                  state   <= LAUNCH_SEND;
               end
            end
            LAUNCH_SEND:
               state <= LAUNCH_WAIT_BUSY;
            LAUNCH_WAIT_BUSY:
               if (!tx_ready)
                  state <= LAUNCH_WAIT_DONE;
            LAUNCH_WAIT_DONE:
               if (tx_ready)
                  state <= LAUNCH_IDLE;
            default:
               state <= LAUNCH_IDLE;
         endcase
      end
   end

endmodule
